// File: rtl/tape_stream_reader_if.sv
// Bundles the tape_stream_reader command, RAM read port and egress stream.
// master = the reader block, slave = its surroundings (host, tape RAM, sink).
interface tape_stream_reader_if #(
  parameter int WORDSIZE  = 64,
  parameter int ADDRWIDTH = 9
);
  logic                 start;
  logic [ADDRWIDTH-1:0] base_addr;
  logic [ADDRWIDTH:0]   num_words;
  logic                 busy;
  logic                 done;
  logic                 ram_en;
  logic [ADDRWIDTH-1:0] ram_addr;
  logic [WORDSIZE-1:0]  ram_do;
  logic [WORDSIZE-1:0]  m_tdata;
  logic                 m_tvalid;
  logic                 m_tready;
  logic                 m_tlast;

  modport master (
    input  start, base_addr, num_words, ram_do, m_tready,
    output busy, done, ram_en, ram_addr, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output start, base_addr, num_words, ram_do, m_tready,
    input  busy, done, ram_en, ram_addr, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/tape_stream_reader.sv
// Streams a contiguous tape RAM region out as valid/ready words, hiding the
// RAM's one-cycle read latency behind a 2-entry prefetch buffer.
module tape_stream_reader #(
  parameter int WORDSIZE  = 64,
  parameter int ADDRWIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  tape_stream_reader_if.master bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_READ   = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [ADDRWIDTH:0] CNT_ONE = 1;

  logic [1:0]           state_reg, state_next;
  logic [ADDRWIDTH:0]   num_reg;
  logic [ADDRWIDTH:0]   issued_reg;
  logic [ADDRWIDTH:0]   popped_reg;
  logic [ADDRWIDTH-1:0] addr_reg;
  logic                 inflight_reg;
  logic [1:0]           count_reg;
  logic                 wr_ptr_reg;
  logic                 rd_ptr_reg;

  logic                 start_ok;
  logic                 push;
  logic                 pop;
  logic                 issue;
  logic                 last_issue;
  logic                 head_last;
  logic [2:0]           pending;
  logic [WORDSIZE-1:0]  entry_data [2];

  always_comb begin
    start_ok   = (state_reg == ST_IDLE) && bus.start;
    push       = inflight_reg;
    pop        = (count_reg != 2'd0) && bus.m_tready;
    // Occupancy the buffer will have once in-flight data lands and this cycle's pop leaves.
    pending    = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    issue      = (state_reg == ST_READ) && (issued_reg != num_reg) && (pending < 3'd2);
    last_issue = issue && ((issued_reg + CNT_ONE) == num_reg);
    head_last  = (count_reg != 2'd0) && ((popped_reg + CNT_ONE) == num_reg);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (bus.start) state_next = (bus.num_words == '0) ? ST_FINISH : ST_READ;
      ST_READ:   if (last_issue) state_next = ST_DRAIN;
      ST_DRAIN:  if (pop && head_last) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      num_reg      <= '0;
      issued_reg   <= '0;
      popped_reg   <= '0;
      addr_reg     <= '0;
      inflight_reg <= 1'b0;
      count_reg    <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= issue;
      if (start_ok) begin
        num_reg    <= bus.num_words;
        addr_reg   <= bus.base_addr;
        issued_reg <= '0;
        popped_reg <= '0;
      end else begin
        if (issue) begin
          issued_reg <= issued_reg + CNT_ONE;
          // Leave the address on the final read so ram_addr parks there.
          if (!last_issue) addr_reg <= addr_reg + 1'b1;
        end
        if (pop) popped_reg <= popped_reg + CNT_ONE;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [WORDSIZE-1:0] data_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= bus.ram_do;
        end
      end
      assign entry_data[gi] = data_reg;
    end
  endgenerate

  assign bus.busy     = (state_reg == ST_READ) || (state_reg == ST_DRAIN);
  assign bus.done     = (state_reg == ST_FINISH);
  assign bus.ram_en   = issue;
  assign bus.ram_addr = addr_reg;
  assign bus.m_tvalid = (count_reg != 2'd0);
  assign bus.m_tdata  = entry_data[rd_ptr_reg];
  assign bus.m_tlast  = head_last;

endmodule

// File: tb/tb_tape_stream_reader.sv
// Scoreboard bench for tape_stream_reader: models the tape RAM, queues the
// expected beats per command and compares them as the stream handshakes.
module tb_tape_stream_reader;

  localparam int WS    = 64;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  typedef struct {
    logic [WS-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tape_stream_reader_if #(.WORDSIZE(WS), .ADDRWIDTH(AW)) bus ();

  tape_stream_reader #(.WORDSIZE(WS), .ADDRWIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [WS-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.ram_en) bus.ram_do <= mem[bus.ram_addr];

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  beat_t         exp_q[$];
  int            cyc = 0;
  int            e0_cyc = 0;
  int            first_valid_cyc = -1;
  int            last_cyc = -1;
  int            done_cyc = -1;
  int            issue_cnt = 0;
  int            pop_cnt = 0;
  int            done_cnt = 0;
  logic [AW-1:0] exp_addr = '0;
  int            tr_mode = 0;

  logic          hold_pend = 1'b0;
  logic [WS-1:0] hold_data;
  logic          hold_last;
  logic          last_hs_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (tr_mode)
        0:       bus.m_tready = 1'b1;
        1:       bus.m_tready = 1'($urandom_range(0, 1));
        default: bus.m_tready = 1'b0;
      endcase
    end
  end

  // Monitor: samples mid-cycle, compares every handshake against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend    = 1'b0;
      last_hs_prev = 1'b0;
    end else begin
      beat_t b;
      logic  pop_now;
      pop_now = bus.m_tvalid && bus.m_tready;
      if (bus.start && !bus.busy && !bus.done) e0_cyc = cyc + 1;
      if (hold_pend) begin
        check_val("hold_valid", 64'(bus.m_tvalid), 64'd1);
        check_val("hold_data", bus.m_tdata, hold_data);
        check_val("hold_last", 64'(bus.m_tlast), 64'(hold_last));
      end
      hold_pend = bus.m_tvalid && !bus.m_tready;
      hold_data = bus.m_tdata;
      hold_last = bus.m_tlast;
      if (bus.m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.ram_en) begin
        check_val("ram_addr", 64'(bus.ram_addr), 64'(exp_addr));
        exp_addr  = exp_addr + 1'b1;
        issue_cnt++;
        check_val("outstanding_le2", 64'((issue_cnt - pop_cnt - (pop_now ? 1 : 0)) <= 2), 64'd1);
      end
      if (last_hs_prev) begin
        check_val("done_after_last", 64'(bus.done), 64'd1);
        check_val("busy_at_done", 64'(bus.busy), 64'd0);
      end
      if (pop_now) begin
        if (exp_q.size() == 0) begin
          check_val("extra_beat", 64'(bus.m_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          b = exp_q.pop_front();
          $display("beat %0d: data=%0h last=%0b", pop_cnt, bus.m_tdata, bus.m_tlast);
          check_val("beat_data", bus.m_tdata, b.data);
          check_val("beat_last", 64'(bus.m_tlast), 64'(b.last));
        end
        pop_cnt++;
        if (bus.m_tlast) last_cyc = cyc;
      end
      last_hs_prev = pop_now && bus.m_tlast;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start_cmd(input int base, input int num);
    beat_t b;
    for (int i = 0; i < num; i++) begin
      b.data = mem[(base + i) % DEPTH];
      b.last = (i == num - 1);
      exp_q.push_back(b);
    end
    @(posedge clk);
    #1;
    exp_addr        = AW'(base);
    issue_cnt       = 0;
    pop_cnt         = 0;
    done_cnt        = 0;
    first_valid_cyc = -1;
    last_cyc        = -1;
    done_cyc        = -1;
    bus.start       = 1'b1;
    bus.base_addr   = AW'(base);
    bus.num_words   = (AW+1)'(num);
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.base_addr = AW'($urandom);
    bus.num_words = (AW+1)'($urandom_range(1, 20));
  endtask

  // Waits for done, pokes start during the done cycle (must be ignored), then audits the command.
  task automatic finish_cmd(input string name, input int num);
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 6000 && !seen; t++) begin
      @(negedge clk);
      seen = bus.done;
    end
    if (!seen) check_val("done_timeout", 64'd0, 64'd1);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    $display("cmd %s: words=%0d beats=%0d reads=%0d dones=%0d", name, num, pop_cnt, issue_cnt, done_cnt);
    check_val("done_count", 64'(done_cnt), 64'd1);
    check_val("busy_after", 64'(bus.busy), 64'd0);
    check_val("reads_issued", 64'(issue_cnt), 64'(num));
    check_val("beats_seen", 64'(pop_cnt), 64'(num));
    check_val("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 64'hD00D_0000_0000_0000 | 64'(i);
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.num_words = '0;
    rst = 1'b1;
    #1;
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_ram_en", 64'(bus.ram_en), 64'd0);
    check_val("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
    check_val("rst_tvalid", 64'(bus.m_tvalid), 64'd0);
    check_val("rst_tlast", 64'(bus.m_tlast), 64'd0);
    check_val("rst_tdata", bus.m_tdata, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    tr_mode = 0;
    start_cmd(0, 8);
    finish_cmd("stream", 8);
    check_val("first_beat_latency", 64'(first_valid_cyc - e0_cyc), 64'd2);
    check_val("last_beat_latency", 64'(last_cyc - e0_cyc), 64'd9);

    start_cmd(510, 4);
    finish_cmd("wrap", 4);

    tr_mode = 2;
    start_cmd(32, 16);
    repeat (12) @(negedge clk);
    check_val("bp_reads_capped", 64'(issue_cnt), 64'd2);
    check_val("bp_tvalid", 64'(bus.m_tvalid), 64'd1);
    tr_mode = 1;
    finish_cmd("backpressure", 16);
    tr_mode = 0;

    start_cmd(7, 0);
    finish_cmd("zero", 0);
    check_val("zero_done_latency", 64'(done_cyc - e0_cyc), 64'd0);

    start_cmd(0, 512);
    finish_cmd("full", 512);

    start_cmd(200, 16);
    repeat (3) @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = AW'(300);
    bus.num_words = (AW+1)'(5);
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b0;
    finish_cmd("start_busy", 16);

    start_cmd(40, 8);
    for (int t = 0; t < 200 && pop_cnt < 3; t++) @(posedge clk);
    check_val("pre_reset_beats", 64'(pop_cnt >= 3), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_busy", 64'(bus.busy), 64'd0);
    check_val("mid_rst_done", 64'(bus.done), 64'd0);
    check_val("mid_rst_ram_en", 64'(bus.ram_en), 64'd0);
    check_val("mid_rst_tvalid", 64'(bus.m_tvalid), 64'd0);
    check_val("mid_rst_tlast", 64'(bus.m_tlast), 64'd0);
    check_val("mid_rst_tdata", bus.m_tdata, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    done_cnt = 0;
    repeat (3) @(negedge clk);
    check_val("post_rst_idle", 64'(bus.busy), 64'd0);
    check_val("post_rst_no_done", 64'(done_cnt), 64'd0);
    start_cmd(100, 8);
    finish_cmd("after_reset", 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tape_stream_reader.md
# tape_stream_reader

Drains a contiguous region of the JSON tape block RAM out to the host as a valid/ready word stream. It owns one read port of the tape RAM, issues sequential reads from a commanded base address, and absorbs the RAM's one-cycle read latency with a 2-entry prefetch buffer. Under full backpressure it loses no word, and with the consumer always ready it sustains one word per cycle. It sits between the tape-writing parser logic and the DMA/AXI-Stream egress path.

## Interface
Parameters:
- WORDSIZE, 64: tape word width in bits.
- ADDRWIDTH, 9: tape RAM address width; address space is 2^ADDRWIDTH words.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDRWIDTH  first tape address; latched on an accepted start.
- num_words  in  ADDRWIDTH+1  word count, 0..2^ADDRWIDTH; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the command completes.
- ram_en  out  1  tape RAM port enable; write enable is never driven by this block.
- ram_addr  out  ADDRWIDTH  tape RAM port address.
- ram_do  in  WORDSIZE  tape RAM read data, valid the cycle after ram_en.
- m_tdata  out  WORDSIZE  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  marks the final word of the command.

## Operation
- States:
  - IDLE: start=1 latches base_addr and num_words. If num_words≠0, go to READ. If num_words=0, go to FINISH.
  - READ: issues reads. Moves to DRAIN once num_words reads have been issued.
  - DRAIN: waits until the last word handshakes, then goes to FINISH.
  - FINISH: done=1 for one cycle, then IDLE.
- Read issue:
  - ram_en=1 in a cycle only if the block is in READ, reads remain to issue, and (buffer occupancy + reads in flight − pop this cycle) < 2.
  - A pop is m_tvalid & m_tready.
  - ram_en is combinational from registered state.
  - ram_addr = base + issued count, mod 2^ADDRWIDTH; addresses wrap from 2^ADDRWIDTH−1 to 0.
  - ram_addr holds its last value when ram_en=0.
- Data capture: ram_do is written into the 2-entry FIFO on the cycle after each issued read. Capture and pop in the same cycle are both legal and keep occupancy unchanged.
- m_tvalid = FIFO not empty. m_tdata = FIFO head.
- m_tlast = 1 exactly when the head is the num_words-th word of the command.
- Beat counter is ADDRWIDTH+1 bits, so num_words = 2^ADDRWIDTH streams the whole RAM exactly once.
- start while busy (READ, DRAIN or FINISH) is ignored. No latch and no effect on the running command.
- start in the same cycle as done: ignored. It is accepted only in IDLE.

## Timing
- Reset values, asserted asynchronously:
  - state=IDLE
  - busy=0, done=0, ram_en=0, ram_addr=0
  - m_tvalid=0, m_tlast=0, m_tdata=0
  - FIFO empty, all counters 0
- Reset mid-command: buffered and in-flight words are discarded, and no done is produced. After rst deasserts, the block waits for a new start.
- Latency, with start accepted at edge E0:
  - busy=1 and ram_en=1 (addr=base) in the cycle after E0.
  - First m_tvalid=1 after E2.
- Throughput: with m_tready held 1, one beat per cycle; N words complete in N+2 cycles after E0.
- done: asserted in the cycle after the m_tlast handshake, with busy=0 in that same cycle.
- num_words=0: no ram_en and no beats; done pulses in the cycle after E0.
- Stream rules:
  - Once m_tvalid=1, m_tdata, m_tlast and m_tvalid hold stable until the handshake.
  - m_tvalid never depends combinationally on m_tready.
- Backpressure:
  - With m_tready=0, at most 2 reads are outstanding or buffered, and ram_en stays 0 once the FIFO is full.
  - When m_tready rises, the stream resumes with no lost or duplicated words.

## Test plan
- Streaming: preload the tape with mem[i]=i. Issue base=0, num_words=8 with m_tready=1. Expect beats 0..7 on consecutive cycles, first beat 2 cycles after start, m_tlast only on 7, and done one cycle after that beat.
- Wrap-around: ADDRWIDTH=9, base=510, num_words=4. Expect reads from addresses 510, 511, 0, 1 and data in that order.
- Backpressure: num_words=16, with m_tready toggled pseudo-randomly and also held 0 for 10 cycles. Expect ram_en=0 while the FIFO is full, all 16 words in order, and m_tdata stable whenever m_tvalid & !m_tready.
- Degenerate and full-range commands: num_words=0 gives done after 1 cycle and no beats. num_words=512 gives exactly 512 beats, with m_tlast on the 512th.
- Start while busy: assert start with different base_addr and num_words mid-command. The original command completes unchanged, and no second done is produced.
- Mid-command reset: assert rst after 3 of 8 beats. All outputs go to their reset values immediately. A new start then streams correctly from its own base.
